// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one GROUP-bit lookahead group per stage, valid/ready on both sides.
// Define CLA_PIPE_SUB_EN to add Sub_i (A-B mode) and the Overflow_o signed-overflow flag.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
`ifdef CLA_PIPE_SUB_EN
    input  logic             Sub_i,
    output logic             Overflow_o,
`endif
    input  logic             Valid_i,
    output logic             Ready_o,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Propagate_o,
    output logic             Generate_o,
    output logic             Valid_o,
    input  logic             Ready_i
);
    localparam int NGRP = WIDTH / GROUP;

    if (WIDTH % GROUP != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end

    // acc rotates right one group per stage: unconsumed A bits sit low, finished sum groups enter at the top
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] b;
        logic             c;
        logic             p;
        logic             g;
`ifdef CLA_PIPE_SUB_EN
        logic             ovf;
`endif
    } stage_t;

    typedef struct packed {
        logic [GROUP-1:0] sum;
        logic             cout;
        logic             c_msb;
        logic             p;
        logic             g;
    } grp_t;

    // Kogge-Stone prefix over the group, then every carry is folded from cin in one level
    function automatic grp_t cla_group(input logic [GROUP-1:0] a, input logic [GROUP-1:0] b,
                                       input logic cin);
        logic [GROUP-1:0] p0, pp, gg, pn, gn;
        logic [GROUP:0]   c;
        grp_t             r;
        p0 = a ^ b;
        pp = p0;
        gg = a & b;
        for (int d = 1; d < GROUP; d = d * 2) begin
            pn = pp;
            gn = gg;
            for (int i = d; i < GROUP; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            pp = pn;
            gg = gn;
        end
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = gg[i] | (pp[i] & cin);
        end
        r.sum   = p0 ^ c[GROUP-1:0];
        r.cout  = c[GROUP];
        r.c_msb = c[GROUP-1];
        r.p     = pp[GROUP-1];
        r.g     = gg[GROUP-1];
        return r;
    endfunction

    stage_t stg_q [NGRP];
    stage_t stg_d [NGRP];
    logic   adv;

    assign Ready_o = ~stg_q[NGRP-1].valid | Ready_i;
    assign adv     = Ready_o;

    always_comb begin
        stage_t           prev;
        grp_t             grp;
        logic [WIDTH-1:0] acc_n;
        for (int s = 0; s < NGRP; s++) begin
            if (s == 0) begin
                prev.valid = Valid_i;
                prev.acc   = Number1_i;
`ifdef CLA_PIPE_SUB_EN
                prev.b     = Number2_i ^ {WIDTH{Sub_i}};
                prev.c     = Carry_i | Sub_i;
                prev.ovf   = 1'b0;
`else
                prev.b     = Number2_i;
                prev.c     = Carry_i;
`endif
                prev.p     = 1'b1;
                prev.g     = 1'b0;
            end else begin
                prev = stg_q[s-1];
            end
            grp   = cla_group(prev.acc[GROUP-1:0], prev.b[GROUP-1:0], prev.c);
            acc_n = prev.acc >> GROUP;
            acc_n[WIDTH-1 -: GROUP] = grp.sum;
            stg_d[s].valid = prev.valid;
            stg_d[s].acc   = acc_n;
            stg_d[s].b     = prev.b >> GROUP;
            stg_d[s].c     = grp.cout;
            stg_d[s].p     = prev.p & grp.p;
            stg_d[s].g     = grp.g | (grp.p & prev.g);
`ifdef CLA_PIPE_SUB_EN
            stg_d[s].ovf   = grp.c_msb ^ grp.cout;
`endif
        end
    end

    // NOTE: data fields are reset along with valid because they drive the outputs directly,
    // which must read 0 during reset; <= keeps every stage sampling pre-edge values.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            for (int s = 0; s < NGRP; s++) begin
                stg_q[s] <= '0;
            end
        end else if (adv) begin
            stg_q <= stg_d;
        end
    end

    assign Valid_o     = stg_q[NGRP-1].valid;
    assign Result_o    = stg_q[NGRP-1].acc;
    assign Carry_o     = stg_q[NGRP-1].c;
    assign Propagate_o = stg_q[NGRP-1].p;
    assign Generate_o  = stg_q[NGRP-1].g;
`ifdef CLA_PIPE_SUB_EN
    assign Overflow_o  = stg_q[NGRP-1].ovf;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomised self-checking bench for cla_pipe_adder against a plain-arithmetic reference model.
module tb_cla_pipe_adder;
    localparam int WIDTH = 32;
    localparam int GROUP = 8;
    localparam int LAT   = WIDTH / GROUP;
`ifdef CLA_PIPE_SUB_EN
    localparam int VW = WIDTH + 4;
`else
    localparam int VW = WIDTH + 3;
`endif
    typedef logic [VW-1:0] vec_t;

    logic             clk;
    logic             Reset_i;
    logic [WIDTH-1:0] Number1_i;
    logic [WIDTH-1:0] Number2_i;
    logic             Carry_i;
    logic             Valid_i;
    logic             Ready_o;
    logic [WIDTH-1:0] Result_o;
    logic             Carry_o;
    logic             Propagate_o;
    logic             Generate_o;
    logic             Valid_o;
    logic             Ready_i;
`ifdef CLA_PIPE_SUB_EN
    logic             Sub_i;
    logic             Overflow_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    vec_t exp_q[$];

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .Clock_i     (clk),
        .Reset_i     (Reset_i),
        .Number1_i   (Number1_i),
        .Number2_i   (Number2_i),
        .Carry_i     (Carry_i),
`ifdef CLA_PIPE_SUB_EN
        .Sub_i       (Sub_i),
        .Overflow_o  (Overflow_o),
`endif
        .Valid_i     (Valid_i),
        .Ready_o     (Ready_o),
        .Result_o    (Result_o),
        .Carry_o     (Carry_o),
        .Propagate_o (Propagate_o),
        .Generate_o  (Generate_o),
        .Valid_o     (Valid_o),
        .Ready_i     (Ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: wide integer add; P is AND of a^b, G is carry-out of a+b alone.
    function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic             cc;
        logic [WIDTH:0]   s;
        logic [WIDTH:0]   g;
        bb = sub ? ~b : b;
        cc = sub | cin;
        s  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
        g  = {1'b0, a} + {1'b0, bb};
`ifdef CLA_PIPE_SUB_EN
        return {(a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]),
                s[WIDTH], &(a ^ bb), g[WIDTH], s[WIDTH-1:0]};
`else
        return {s[WIDTH], &(a ^ bb), g[WIDTH], s[WIDTH-1:0]};
`endif
    endfunction

    function automatic vec_t mk(input logic c, input logic p, input logic g, input logic ovf,
                                input logic [WIDTH-1:0] res);
`ifdef CLA_PIPE_SUB_EN
        return {ovf, c, p, g, res};
`else
        if (ovf) return {c, p, g, res};
        return {c, p, g, res};
`endif
    endfunction

    function automatic vec_t out_vec();
`ifdef CLA_PIPE_SUB_EN
        return {Overflow_o, Carry_o, Propagate_o, Generate_o, Result_o};
`else
        return {Carry_o, Propagate_o, Generate_o, Result_o};
`endif
    endfunction

    task automatic set_sub(input logic sub);
`ifdef CLA_PIPE_SUB_EN
        Sub_i = sub;
`else
        if (sub) Carry_i = Carry_i;
`endif
    endtask

    task automatic check_idle(input string tag, input int n);
        Valid_i = 1'b0;
        Ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check(tag, Valid_o, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, output vec_t got, output int lat);
        Number1_i = a;
        Number2_i = b;
        Carry_i   = cin;
        set_sub(sub);
        Valid_i   = 1'b1;
        Ready_i   = 1'b1;
        @(posedge clk); #1;
        Valid_i = 1'b0;
        lat = 1;
        while (!Valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = out_vec();
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input string tag, input int n_beats, input int ready_pct,
                              input int valid_pct, output int pops, output int first_pop,
                              output int last_pop);
        int               sent = 0;
        int               cyc = 0;
        logic             have = 1'b0;
        logic             stall_prev = 1'b0;
        logic [WIDTH-1:0] a = '0;
        logic [WIDTH-1:0] b = '0;
        logic             cin = 1'b0;
        logic             sub = 1'b0;
        vec_t             held = '0;
        vec_t             exp;
        pops = 0;
        first_pop = -1;
        last_pop = -1;
        while ((sent < n_beats || exp_q.size() != 0) && cyc < 5000) begin
            if (!have && sent < n_beats && $urandom_range(99) < valid_pct) begin
                a    = $urandom;
                b    = $urandom;
                cin  = 1'($urandom_range(1));
`ifdef CLA_PIPE_SUB_EN
                sub  = 1'($urandom_range(1));
`endif
                have = 1'b1;
            end
            Valid_i   = have;
            Number1_i = a;
            Number2_i = b;
            Carry_i   = cin;
            set_sub(sub);
            Ready_i   = ($urandom_range(99) < ready_pct);
            #1;
            check({tag, "_ready_rule"}, Ready_o, !Valid_o || Ready_i);
            if (stall_prev) check({tag, "_stall_hold"}, out_vec(), held);
            if (Valid_o && Ready_i) begin
                check({tag, "_pop_expected"}, exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check({tag, "_beat"}, out_vec(), exp);
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
            if (have && Ready_o) begin
                exp_q.push_back(model(a, b, cin, sub));
                have = 1'b0;
                sent++;
            end
            stall_prev = Valid_o && !Ready_i;
            held = out_vec();
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_drained"}, (exp_q.size() == 0) && (sent == n_beats), 1'b1);
        check_idle({tag, "_no_extra"}, 6);
    endtask

    initial begin
        vec_t got;
        int   lat;
        int   pops;
        int   first_pop;
        int   last_pop;

        Reset_i   = 1'b1;
        Valid_i   = 1'b0;
        Ready_i   = 1'b1;
        Number1_i = '0;
        Number2_i = '0;
        Carry_i   = 1'b0;
        set_sub(1'b0);
        #3;
        check("reset_outputs", out_vec(), '0);
        check("reset_valid", Valid_o, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset_i = 1'b0;
        @(posedge clk); #1;

        // T1: three beats in flight, then reset discards them
        for (int k = 0; k < 3; k++) begin
            Number1_i = $urandom;
            Number2_i = $urandom;
            Carry_i   = 1'($urandom_range(1));
            Valid_i   = 1'b1;
            @(posedge clk); #1;
        end
        Valid_i = 1'b0;
        #1 Reset_i = 1'b1;
        #2;
        check("t1_rst_outputs", out_vec(), '0);
        check("t1_rst_valid", Valid_o, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset_i = 1'b0;
        check_idle("t1_no_emit", 10);

        // T2: single beat latency and value
        send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        check("t2_latency", lat, LAT);
        check("t2_value", got, mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100));
        check_idle("t2_idle", 2);

        // T3: full carry chain, propagate vs generate
        send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, got, lat);
        check("t3_prop_chain", got, mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000));
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
        check("t3_gen_chain", got, mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000));

        // T4: back-to-back stream
        run_stream("t4", 16, 100, 100, pops, first_pop, last_pop);
        check("t4_count", pops, 16);
        check("t4_consecutive", last_pop - first_pop, 15);

        // T5: random backpressure, then random bubbles plus backpressure
        run_stream("t5", 200, 50, 100, pops, first_pop, last_pop);
        check("t5_count", pops, 200);
        run_stream("t5b", 100, 70, 60, pops, first_pop, last_pop);
        check("t5b_count", pops, 100);

`ifdef CLA_PIPE_SUB_EN
        // T6: subtract mode with signed overflow
        send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, got, lat);
        check("t6_sub_ovf_res", got[WIDTH-1:0], 32'h7FFF_FFFF);
        check("t6_sub_ovf_flags", {got[VW-1], got[VW-2]}, 2'b11);
        send_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, got, lat);
        check("t6_sub_neg_res", got[WIDTH-1:0], 32'hFFFF_FFFE);
        check("t6_sub_neg_flags", {got[VW-1], got[VW-2]}, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
